// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Round-robin arbiter for the common data bus. Four functional units
// (0=ALU, 1=MUL, 2=DIV, 3=LSU) raise req_valid when a result is ready. One
// of them is granted per cycle. The granted tag/data pair is broadcast on
// the registered CDB outputs one cycle later.
//
// Each requester also has a saturating wait counter. If any requester has
// been left waiting for four consecutive eligible cycles, the sticky
// err_starve flag is raised. Correct round-robin arbitration bounds the
// wait at three, so this flag indicates a broken arbiter or an external
// grant override.
//
// Ports
//   clk         in   clock, all state updates on posedge
//   reset       in   asynchronous reset, active-low
//   flush       in   branch-mispredict flush; blocks grants and freezes
//                    the wait counters
//   req_valid   in   [3:0]          per-unit result-ready
//   req_tag     in   [4*W_TAG-1:0]  packed tags, unit i at [i*W_TAG +: W_TAG]
//   req_data    in   [4*W_DATA-1:0] packed data, unit i at [i*W_DATA +: W_DATA]
//   req_grant   out  [3:0]          combinational one-hot (or zero) grant
//   cdb_valid   out  registered broadcast valid
//   cdb_tag     out  [W_TAG-1:0]    registered broadcast tag
//   cdb_data    out  [W_DATA-1:0]   registered broadcast data (regfile wdata)
//   err_starve  out  sticky starvation error
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int W_DATA = 32,
   parameter int W_TAG  = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic [3:0]          req_valid,
   input  logic [4*W_TAG-1:0]  req_tag,
   input  logic [4*W_DATA-1:0] req_data,
   output logic [3:0]          req_grant,
   output logic                cdb_valid,
   output logic [W_TAG-1:0]    cdb_tag,
   output logic [W_DATA-1:0]   cdb_data,
   output logic                err_starve
);

   localparam int N_REQ = 4;

   logic [1:0]        rr_ptr;
   logic [2:0]        wait_cnt [N_REQ];
   logic [2:0]        wait_nxt [N_REQ];
   logic [3:0]        grant;
   logic [1:0]        grant_idx;
   logic              any_grant;
   logic [W_TAG-1:0]  sel_tag;
   logic [W_DATA-1:0] sel_data;
   logic              starve_hit;

   // Return the first valid requester at or above ptr (modulo 4), one-hot.
   function automatic logic [3:0] rr_pick(input logic [3:0] vld,
                                          input logic [1:0] ptr);
      logic [3:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = 4'b0000;
      found = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + 2'(k);
         if (!found && vld[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   function automatic logic [2:0] sat_inc(input logic [2:0] c);
      return (c == 3'd7) ? c : c + 3'd1;
   endfunction

   // Grant is gated by reset and flush. The arbitration path and the
   // state updates below all use this one net. An override of the grant
   // is therefore seen consistently by the CDB register, by rr_ptr and
   // by the wait counters.
   assign grant     = (!reset || flush) ? 4'b0000 : rr_pick(req_valid, rr_ptr);
   assign req_grant = grant;
   assign any_grant = |grant;
   assign grant_idx = onehot_idx(grant);

   always_comb begin
      sel_tag  = req_tag[grant_idx*W_TAG +: W_TAG];
      sel_data = req_data[grant_idx*W_DATA +: W_DATA];
   end

   // Wait counters count consecutive cycles a valid requester goes
   // ungranted. They are frozen during flush, so a long flush can never
   // look like starvation.
   always_comb begin
      starve_hit = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         wait_nxt[i] = wait_cnt[i];
         if (!flush) begin
            if (grant[i] || !req_valid[i]) begin
               wait_nxt[i] = 3'd0;
            end else begin
               wait_nxt[i] = sat_inc(wait_cnt[i]);
            end
         end
         if (wait_nxt[i] >= 3'd4) starve_hit = 1'b1;
      end
   end

   // ---- CDB broadcast register, round-robin pointer, starvation state ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cdb_valid  <= 1'b0;
         cdb_tag    <= '0;
         cdb_data   <= '0;
         rr_ptr     <= 2'd0;
         err_starve <= 1'b0;
         for (int i = 0; i < N_REQ; i++) begin
            wait_cnt[i] <= 3'd0;
         end
      end else begin
         cdb_valid <= any_grant && !flush;
         if (any_grant) begin
            cdb_tag  <= sel_tag;
            cdb_data <= sel_data;
            rr_ptr   <= grant_idx + 2'd1;
         end
         for (int i = 0; i < N_REQ; i++) begin
            wait_cnt[i] <= wait_nxt[i];
         end
         if (starve_hit) err_starve <= 1'b1;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Directed bench for cdb_arbiter. The stimulus process checks the
// combinational grant. On every grant it pushes the expected CDB
// tag/data pair. A monitor pops one entry at each negedge where
// cdb_valid is high and compares it with the broadcast.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int W_DATA = 32;
   localparam int W_TAG  = 6;

   typedef struct packed {
      logic [W_TAG-1:0]  tag;
      logic [W_DATA-1:0] data;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic                flush;
   logic [3:0]          req_valid;
   logic [4*W_TAG-1:0]  req_tag;
   logic [4*W_DATA-1:0] req_data;
   logic [3:0]          req_grant;
   logic                cdb_valid;
   logic [W_TAG-1:0]    cdb_tag;
   logic [W_DATA-1:0]   cdb_data;
   logic                err_starve;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   cdb_arbiter #(.W_DATA(W_DATA), .W_TAG(W_TAG)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_tag    (req_tag),
      .req_data   (req_data),
      .req_grant  (req_grant),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .err_starve (err_starve)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [W_TAG-1:0] tag, input logic [W_DATA-1:0] data);
      req_tag[i*W_TAG +: W_TAG]    = tag;
      req_data[i*W_DATA +: W_DATA] = data;
   endtask

   // Drive one cycle: apply inputs, check the grant, and queue the
   // expected broadcast. Then advance past the next posedge.
   task automatic cyc(input string name, input logic [3:0] vld, input logic fl,
                      input logic [3:0] exp_g);
      exp_t e;
      req_valid = vld;
      flush     = fl;
      #1;
      check(name, 64'(req_grant), 64'(exp_g));
      for (int i = 0; i < 4; i++) begin
         if (exp_g[i]) begin
            e.tag  = req_tag[i*W_TAG +: W_TAG];
            e.data = req_data[i*W_DATA +: W_DATA];
            sb_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every broadcast must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset === 1'b1 && cdb_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL cdb_unexpected: got tag %0h data %0h required no broadcast", cdb_tag, cdb_data);
         end else begin
            e = sb_q.pop_front();
            check("cdb_tag", 64'(cdb_tag), 64'(e.tag));
            check("cdb_data", 64'(cdb_data), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      req_valid = 4'hF;
      req_tag   = '0;
      req_data  = '0;

      // Reset state, with all requesters valid: the grant must still be zero.
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_grant", 64'(req_grant), 64'h0);
      check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
      check("rst_cdb_tag", 64'(cdb_tag), 64'h0);
      check("rst_cdb_data", 64'(cdb_data), 64'h0);
      check("rst_err", 64'(err_starve), 64'h0);
      req_valid = 4'h0;
      reset     = 1'b1;

      // Single requester 1.
      set_req(1, 6'h15, 32'hDEAD_BEEF);
      cyc("single_grant", 4'b0010, 1'b0, 4'b0010);
      check("single_cdb_valid", 64'(cdb_valid), 64'h1);
      check("single_rr_ptr", 64'(dut.rr_ptr), 64'h2);
      cyc("single_idle", 4'b0000, 1'b0, 4'b0000);
      check("idle_cdb_valid", 64'(cdb_valid), 64'h0);
      check("idle_cdb_tag_hold", 64'(cdb_tag), 64'h15);

      // All four requesters valid for 8 cycles from a fresh reset.
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 6'(6'h10 + i), 32'hC0DE_0000 + i);
      for (int n = 0; n < 8; n++) begin
         cyc("rr_all4", 4'b1111, 1'b0, 4'(1 << (n % 4)));
      end
      check("rr_all4_err", 64'(err_starve), 64'h0);
      cyc("rr_all4_idle", 4'b0000, 1'b0, 4'b0000);

      // Wrap: reach rr_ptr=3, then requesters 3 and 0 compete.
      set_req(2, 6'h22, 32'h2222_0002);
      set_req(3, 6'h33, 32'h3333_0003);
      set_req(0, 6'h30, 32'h3030_0000);
      cyc("wrap_pre", 4'b0100, 1'b0, 4'b0100);
      check("wrap_rr3", 64'(dut.rr_ptr), 64'h3);
      cyc("wrap_g3", 4'b1001, 1'b0, 4'b1000);
      cyc("wrap_g0", 4'b0001, 1'b0, 4'b0001);
      check("wrap_rr1", 64'(dut.rr_ptr), 64'h1);

      // Flush: no grant. The broadcast from the prior grant is cleared.
      // Counters are frozen, so a long flush raises no starvation.
      cyc("flush_g0", 4'b0111, 1'b1, 4'b0000);
      check("flush_cdb_valid", 64'(cdb_valid), 64'h0);
      for (int n = 0; n < 4; n++) cyc("flush_gN", 4'b0111, 1'b1, 4'b0000);
      check("flush_err", 64'(err_starve), 64'h0);
      check("flush_rr", 64'(dut.rr_ptr), 64'h1);
      cyc("post_flush_g1", 4'b0111, 1'b0, 4'b0010);
      cyc("post_flush_g2", 4'b0101, 1'b0, 4'b0100);
      cyc("post_flush_g0", 4'b0001, 1'b0, 4'b0001);
      cyc("post_flush_idle", 4'b0000, 1'b0, 4'b0000);

      // Starvation: the grant is overridden to zero while requester 2 waits.
      req_valid = 4'b0100;
      force dut.grant = 4'b0000;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk);
         #1;
      end
      check("starve_3_cycles", 64'(err_starve), 64'h0);
      @(posedge clk);
      #1;
      check("starve_4_cycles", 64'(err_starve), 64'h1);
      release dut.grant;
      cyc("starve_release_idle", 4'b0000, 1'b0, 4'b0000);
      cyc("starve_regrant", 4'b0100, 1'b0, 4'b0100);
      cyc("starve_idle", 4'b0000, 1'b0, 4'b0000);
      check("starve_sticky", 64'(err_starve), 64'h1);

      // Asynchronous reset between edges while a broadcast is live.
      set_req(1, 6'h11, 32'h1111_1111);
      cyc("ar_grant", 4'b0010, 1'b0, 4'b0010);
      check("ar_cdb_live", 64'(cdb_valid), 64'h1);
      req_valid = 4'b1100;
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("ar_cdb_valid", 64'(cdb_valid), 64'h0);
      check("ar_cdb_tag", 64'(cdb_tag), 64'h0);
      check("ar_cdb_data", 64'(cdb_data), 64'h0);
      check("ar_err_clear", 64'(err_starve), 64'h0);
      check("ar_grant_in_reset", 64'(req_grant), 64'h0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc("ar_post_grant2", 4'b1100, 1'b0, 4'b0100);
      cyc("ar_post_idle", 4'b0000, 1'b0, 4'b0000);
      cyc("ar_post_idle2", 4'b0000, 1'b0, 4'b0000);

      check("sb_drained", 64'(sb_q.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
